// File: rtl/ram_io_responder_if.sv
// Bus bundle between the CPU memory controller / UART host and ram_io_responder.
// master: controller + host side; slave: the responder.
interface ram_io_responder_if;
  logic [31:0] mem_ram_addr;
  logic [7:0]  mem_ram_data;
  logic        mem_ram_wr;
  logic [7:0]  ram_data;
  logic        io_buffer_full;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_ready;
  logic        tx_overflow;
  logic        io_halt;

  modport master (
    output mem_ram_addr, mem_ram_data, mem_ram_wr,
    output uart_tx_ready, uart_rx_valid, uart_rx_data,
    input  ram_data, io_buffer_full, uart_tx_valid, uart_tx_data,
    input  uart_rx_ready, tx_overflow, io_halt
  );

  modport slave (
    input  mem_ram_addr, mem_ram_data, mem_ram_wr,
    input  uart_tx_ready, uart_rx_valid, uart_rx_data,
    output ram_data, io_buffer_full, uart_tx_valid, uart_tx_data,
    output uart_rx_ready, tx_overflow, io_halt
  );
endinterface

// File: rtl/ram_io_responder.sv
// Byte RAM responder with a memory-mapped I/O window at addr[17:16]==2'b11:
// UART TX FIFO, RX holding register and sticky halt flag.
// Optional feature macro: IO_RX_EN (RX holding register and handshake).
module ram_io_responder #(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned TX_DEPTH_LOG = 3
) (
  input logic               clk,
  input logic               rst,
  input logic               rdy,
  ram_io_responder_if.slave bus
);
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG;

  typedef logic [TX_DEPTH_LOG:0]   cnt_t;
  typedef logic [TX_DEPTH_LOG-1:0] ptr_t;

  logic [7:0] ram_q    [0:(2**ADDR_WIDTH)-1];
  logic [7:0] tx_buf_q [0:TX_DEPTH-1];

  ptr_t       tx_wptr_q, tx_wptr_d;
  ptr_t       tx_rptr_q, tx_rptr_d;
  cnt_t       tx_cnt_q, tx_cnt_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       halt_q, halt_d;
  logic [7:0] ram_data_q, ram_data_d;

  logic [ADDR_WIDTH-1:0] ram_idx;
  logic       is_io, sel_data, sel_stat, ram_rd, ram_wr;
  logic       tx_full, tx_pop, push_req, push_ok;
  logic [7:0] rx_rd_byte;
  logic       rx_stat;
  logic       unused_addr;

  assign ram_idx  = bus.mem_ram_addr[ADDR_WIDTH-1:0];
  assign is_io    = (bus.mem_ram_addr[17:16] == 2'b11);
  assign sel_data = is_io && (bus.mem_ram_addr[15:0] == 16'h0000);
  assign sel_stat = is_io && (bus.mem_ram_addr[15:0] == 16'h0004);
  assign ram_rd   = !bus.mem_ram_wr && !is_io;
  assign ram_wr   = rdy && !rst && bus.mem_ram_wr && !is_io;
  assign unused_addr = ^bus.mem_ram_addr[31:18];

  assign tx_full  = (tx_cnt_q == cnt_t'(TX_DEPTH));
  assign tx_pop   = rdy && (tx_cnt_q != '0) && bus.uart_tx_ready;
  assign push_req = rdy && bus.mem_ram_wr && sel_data;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok  = push_req && (!tx_full || tx_pop);

  assign bus.uart_tx_valid  = (tx_cnt_q != '0);
  assign bus.uart_tx_data   = (tx_cnt_q != '0) ? tx_buf_q[tx_rptr_q] : 8'h00;
  assign bus.io_buffer_full = (tx_cnt_q >= cnt_t'(TX_DEPTH - 2));
  assign bus.tx_overflow    = tx_ovf_q;
  assign bus.io_halt        = halt_q;
  assign bus.ram_data       = ram_data_q;

`ifdef IO_RX_EN
  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_pop, rx_cap;

  // rx_pop and rx_cap are mutually exclusive: capture needs the register empty.
  assign rx_pop = rdy && !bus.mem_ram_wr && sel_data && rx_full_q;
  assign rx_cap = rdy && bus.uart_rx_valid && !rx_full_q;

  assign bus.uart_rx_ready = !rx_full_q;
  assign rx_rd_byte        = rx_full_q ? rx_data_q : 8'h00;
  assign rx_stat           = rx_full_q;

  // RX holding register next state.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    if (rx_pop) begin
      rx_full_d = 1'b0;
    end else if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_data_d = bus.uart_rx_data;
    end
  end

  // RX holding register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      rx_full_q <= rx_full_d;
      rx_data_q <= rx_data_d;
    end
  end
`else
  logic unused_rx;

  assign bus.uart_rx_ready = 1'b0;
  assign rx_rd_byte        = 8'h00;
  assign rx_stat           = 1'b0;
  assign unused_rx         = ^{bus.uart_rx_valid, bus.uart_rx_data};
`endif

  // TX FIFO pointers/count, sticky flags and the non-RAM read value.
  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_cnt_d   = tx_cnt_q;
    tx_ovf_d   = tx_ovf_q;
    halt_d     = halt_q;
    ram_data_d = 8'h00;

    if (push_ok) tx_wptr_d = tx_wptr_q + ptr_t'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + ptr_t'(1);
    case ({push_ok, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + cnt_t'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - cnt_t'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    if (push_req && !push_ok) tx_ovf_d = 1'b1;
    if (rdy && bus.mem_ram_wr && sel_stat) halt_d = 1'b1;

    if (!bus.mem_ram_wr) begin
      if (sel_data)      ram_data_d = rx_rd_byte;
      else if (sel_stat) ram_data_d = {6'b0, tx_full, rx_stat};
    end
  end

  // Control state registers; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      halt_q    <= halt_d;
    end
  end

  // Registered read data: RAM byte for RAM reads, I/O value or zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_data_q <= '0;
    end else if (rdy) begin
      ram_data_q <= ram_rd ? ram_q[ram_idx] : ram_data_d;
    end
  end

  // Byte RAM write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[ram_idx] <= bus.mem_ram_data;
  end

  // TX FIFO storage write.
  always_ff @(posedge clk) begin
    if (push_ok) tx_buf_q[tx_wptr_q] <= bus.mem_ram_data;
  end
endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios with literal
// expectations, then randomized traffic against a queue/array reference model.
module tb_ram_io_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  always #5 clk = ~clk;

  ram_io_responder_if bus ();

  ram_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH_LOG(3)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

`ifdef IO_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  // Reference model state.
  logic [7:0] m_mem [0:131071];
  logic [7:0] m_txq [$];
  logic [7:0] m_ram_data = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_halt = 1'b0;
  logic       m_rx_full = 1'b0;
  logic [7:0] m_rx_byte = 8'h00;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  bit         g_txr = 1'b0;
  bit         g_rxv = 1'b0;
  logic [7:0] g_rxd = 8'h00;
  bit         g_rdy = 1'b1;

  logic [17:0] pool [9] = '{18'h00000, 18'h00010, 18'h00100, 18'h00101, 18'h00102,
                            18'h00103, 18'h1FFFF, 18'h2ABCD, 18'h1ABCD};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the model, using the inputs applied for this edge.
  task automatic model_step();
    logic [31:0] a;
    logic [17:0] off;
    bit          io, pre_rx, pop;
    int          n;
    if (rst) begin
      m_txq.delete();
      m_ram_data = 8'h00;
      m_ovf      = 1'b0;
      m_halt     = 1'b0;
      m_rx_full  = 1'b0;
    end else if (rdy) begin
      a      = bus.mem_ram_addr;
      off    = a[17:0];
      io     = (a[17:16] == 2'b11);
      pre_rx = m_rx_full;
      n      = m_txq.size();
      pop    = (n > 0) && bus.uart_tx_ready;
      if (pop) void'(m_txq.pop_front());
      if (bus.mem_ram_wr) begin
        m_ram_data = 8'h00;
        if (!io) m_mem[a[16:0]] = bus.mem_ram_data;
        else if (off == 18'h30000) begin
          if (n < 8 || pop) m_txq.push_back(bus.mem_ram_data);
          else m_ovf = 1'b1;
        end else if (off == 18'h30004) m_halt = 1'b1;
      end else begin
        if (!io) m_ram_data = m_mem[a[16:0]];
        else if (off == 18'h30000) begin
          if (RX_EN && pre_rx) begin
            m_ram_data = m_rx_byte;
            m_rx_full  = 1'b0;
          end else m_ram_data = 8'h00;
        end else if (off == 18'h30004) m_ram_data = {6'b0, n == 8, pre_rx};
        else m_ram_data = 8'h00;
      end
      if (RX_EN && !pre_rx && bus.uart_rx_valid) begin
        m_rx_full = 1'b1;
        m_rx_byte = bus.uart_rx_data;
      end
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ram_data", bus.ram_data, m_ram_data);
      chk("tx_valid", bus.uart_tx_valid, m_txq.size() != 0);
      chk("tx_data", bus.uart_tx_data, (m_txq.size() != 0) ? m_txq[0] : 8'h00);
      chk("io_buffer_full", bus.io_buffer_full, m_txq.size() >= 6);
      chk("rx_ready", bus.uart_rx_ready, RX_EN ? !m_rx_full : 1'b0);
      chk("tx_overflow", bus.tx_overflow, m_ovf);
      chk("io_halt", bus.io_halt, m_halt);
    end
  end

  task automatic step(input bit r, input bit en, input bit wr, input logic [31:0] a,
                      input logic [7:0] d, input bit txr, input bit rxv, input logic [7:0] rxd);
    rst               = r;
    rdy               = en;
    bus.mem_ram_wr    = wr;
    bus.mem_ram_addr  = a;
    bus.mem_ram_data  = d;
    bus.uart_tx_ready = txr;
    bus.uart_rx_valid = rxv;
    bus.uart_rx_data  = rxd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic op(input bit wr, input logic [31:0] a, input logic [7:0] d);
    step(1'b0, g_rdy, wr, a, d, g_txr, g_rxv, g_rxd);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0]  word_b [4];
    logic [31:0] hi, a;
    logic [7:0]  d;
    bit          r, wr;
    int unsigned k;

    word_b = '{8'h78, 8'h56, 8'h34, 8'h12};
    bus.mem_ram_wr    = 1'b0;
    bus.mem_ram_addr  = '0;
    bus.mem_ram_data  = '0;
    bus.uart_tx_ready = 1'b0;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = '0;

    do_reset();
    do_reset();
    chk_en = 1'b1;
    chk("rst_ram_data", bus.ram_data, 8'h00);
    chk("rst_tx_valid", bus.uart_tx_valid, 1'b0);
    chk("rst_tx_data", bus.uart_tx_data, 8'h00);
    chk("rst_rx_ready", bus.uart_rx_ready, RX_EN);
    chk("rst_ibf", bus.io_buffer_full, 1'b0);
    chk("rst_ovf", bus.tx_overflow, 1'b0);
    chk("rst_halt", bus.io_halt, 1'b0);

    for (int unsigned i = 0; i < 9; i++) op(1'b1, {14'h0, pool[i]}, 8'($urandom));

    // RAM write then read, one cycle latency.
    op(1'b1, 32'h10, 8'hA5);
    chk("ram_wr_zero", bus.ram_data, 8'h00);
    op(1'b0, 32'h10, 8'h00);
    chk("ram_rd_a5", bus.ram_data, 8'hA5);

    // Word store / back-to-back byte loads.
    for (int unsigned i = 0; i < 4; i++) op(1'b1, 32'h100 + i, word_b[i]);
    for (int unsigned i = 0; i < 4; i++) begin
      op(1'b0, 32'h100 + i, 8'h00);
      chk("word_byte", bus.ram_data, word_b[i]);
    end

    // TX fill with the host stalled.
    do_reset();
    g_txr = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      op(1'b1, 32'h30000, 8'h41 + 8'(i));
      chk("fill_ibf", bus.io_buffer_full, i >= 5);
    end
    chk("fill_head", bus.uart_tx_data, 8'h41);
    chk("fill_ovf", bus.tx_overflow, 1'b0);

    // Push while full with a same-cycle pop is accepted.
    g_txr = 1'b1;
    op(1'b1, 32'h30000, 8'h5A);
    g_txr = 1'b0;
    chk("pp_ovf", bus.tx_overflow, 1'b0);
    op(1'b0, 32'h30004, 8'h00);
    chk("pp_status_full", bus.ram_data, 8'h02);
    chk("pp_head", bus.uart_tx_data, 8'h42);

    // Push while full without a pop is dropped.
    op(1'b1, 32'h30000, 8'h5B);
    chk("ovf_set", bus.tx_overflow, 1'b1);

    g_txr = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      chk("drain", bus.uart_tx_data, (i < 7) ? 8'h42 + 8'(i) : 8'h5A);
      op(1'b0, 32'h0, 8'h00);
    end
    g_txr = 1'b0;
    chk("drained", bus.uart_tx_valid, 1'b0);

    // RX path.
    g_rxv = 1'b1;
    g_rxd = 8'h33;
    op(1'b0, 32'h0, 8'h00);
    g_rxv = 1'b0;
    chk("rx_ready_low", bus.uart_rx_ready, 1'b0);
    op(1'b0, 32'h30004, 8'h00);
    chk("rx_status", bus.ram_data, RX_EN ? 8'h01 : 8'h00);
    op(1'b0, 32'h30000, 8'h00);
    chk("rx_byte", bus.ram_data, RX_EN ? 8'h33 : 8'h00);
    op(1'b0, 32'h30000, 8'h00);
    chk("rx_empty_read", bus.ram_data, 8'h00);

    // Same-cycle CPU pop and host offer.
    g_rxv = 1'b1;
    g_rxd = 8'h33;
    op(1'b0, 32'h0, 8'h00);
    g_rxd = 8'h44;
    op(1'b0, 32'h30000, 8'h00);
    chk("rx_pop_old", bus.ram_data, RX_EN ? 8'h33 : 8'h00);
    chk("rx_ready_after_pop", bus.uart_rx_ready, RX_EN);
    op(1'b0, 32'h0, 8'h00);
    g_rxv = 1'b0;
    chk("rx_recaptured", bus.uart_rx_ready, 1'b0);
    op(1'b0, 32'h30000, 8'h00);
    chk("rx_new_byte", bus.ram_data, RX_EN ? 8'h44 : 8'h00);

    // Halt, rdy hold, reset.
    op(1'b1, 32'h30004, 8'h00);
    chk("halt_set", bus.io_halt, 1'b1);
    op(1'b0, 32'h10, 8'h00);
    chk("pre_hold", bus.ram_data, 8'hA5);
    g_rdy = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      op(1'b0, 32'h100, 8'h00);
      chk("rdy_hold", bus.ram_data, 8'hA5);
    end
    g_rdy = 1'b1;
    op(1'b1, 32'h30000, 8'h77);
    chk("pre_rst_valid", bus.uart_tx_valid, 1'b1);
    do_reset();
    chk("post_rst_valid", bus.uart_tx_valid, 1'b0);
    chk("post_rst_halt", bus.io_halt, 1'b0);

    // Randomized traffic.
    for (int unsigned c = 0; c < 4000; c++) begin
      hi = $urandom();
      r  = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 7))
        0, 1, 2: begin
          k = $urandom_range(0, 8);
          a = {hi[31:18], pool[k]};
        end
        3, 4:    a = {hi[31:18], 18'h30000};
        5:       a = {hi[31:18], 18'h30004};
        6:       a = {hi[31:18], 18'h30001};
        default: a = {hi[31:18], 18'h3FFF8};
      endcase
      wr = !r && ($urandom_range(0, 1) == 1);
      d  = 8'($urandom);
      step(r, ($urandom_range(0, 9) != 0), wr, a, d,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
